// File: rtl/psum_post_pkg.sv
// Shared Q8.8 fixed-point definitions for the PE array and the column post-processor.
package psum_post_pkg;

    localparam int Q_WIDTH   = 16;
    localparam int FRAC_BITS = 8;

    localparam logic [Q_WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [Q_WIDTH-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ACT_PASS  = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_LEAKY = 2'b10,
        ACT_RSVD  = 2'b11
    } act_mode_e;

    // Clamp a 17-bit sign-extended sum back into Q8.8. The top two bits
    // disagree exactly when the sum left the 16-bit signed range.
    function automatic logic [Q_WIDTH-1:0] sat_q88(input logic [Q_WIDTH:0] v);
        if (v[Q_WIDTH] != v[Q_WIDTH-1]) begin
            return v[Q_WIDTH] ? SAT_MIN : SAT_MAX;
        end
        return v[Q_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, first-word fall-through head and a
// drop strobe for writes refused because the buffer is full.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full;
    logic             do_rd;
    logic             do_wr;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign do_rd   = rd_en_i && !empty_o;
    // A full FIFO still accepts a write when the same edge frees a slot.
    assign do_wr   = wr_en_i && (!full || do_rd);
    assign drop_o  = wr_en_i && full && !do_rd;

    // Head is forced to zero while empty so stale storage never shows.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Occupancy next-state from the write/read pair.
    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the count and the empty gate make stale words invisible.
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/psum_post.sv
// Column post-processor: bias add with saturation, activation, and an output
// FIFO that never back-pressures the array.
module psum_post
    import psum_post_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LEAK_SHIFT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   psum_valid_in,
    input  logic [Q_WIDTH-1:0]     psum_in,
    input  logic                   bias_load_in,
    input  logic [Q_WIDTH-1:0]     bias_in,
    input  logic [1:0]             mode_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Q_WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow_err
);

    logic [Q_WIDTH-1:0]        bias_q;
    logic                      s1_valid_q;
    logic signed [Q_WIDTH-1:0] s1_data_q;
    act_mode_e                 s1_mode_q;
    logic                      overflow_q;
    logic [Q_WIDTH:0]          sum_ext;
    logic signed [Q_WIDTH-1:0] act_data;
    logic                      fifo_empty;
    logic                      fifo_drop;

    assign sum_ext = {psum_in[Q_WIDTH-1], psum_in} + {bias_q[Q_WIDTH-1], bias_q};

    // Bias register; a load and a psum on the same edge see the old bias.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q <= '0;
        end else if (bias_load_in) begin
            bias_q <= bias_in;
        end
    end

    // Stage 1: saturated bias add plus the activation mode that travels with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= ACT_PASS;
        end else begin
            s1_valid_q <= psum_valid_in;
            if (psum_valid_in) begin
                s1_data_q <= sat_q88(sum_ext);
                s1_mode_q <= act_mode_e'(mode_in);
            end
        end
    end

    // Stage 2: activation; only negative values are ever modified.
    always_comb begin
        act_data = s1_data_q;
        if (s1_data_q < 0) begin
            case (s1_mode_q)
                ACT_RELU:  act_data = '0;
                ACT_LEAKY: act_data = s1_data_q >>> LEAK_SHIFT;
                default:   ;
            endcase
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (Q_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (s1_valid_q),
        .wr_data_i (act_data),
        .rd_en_i   (out_ready),
        .rd_data_o (out_data),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count),
        .drop_o    (fifo_drop)
    );

    assign out_valid    = !fifo_empty;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_psum_post.sv
// Self-checking bench for psum_post: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_psum_post;

    localparam int DEPTH      = 4;
    localparam int LEAK_SHIFT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psum_valid_in = 1'b0;
    logic [15:0] psum_in = '0;
    logic        bias_load_in = 1'b0;
    logic [15:0] bias_in = '0;
    logic [1:0]  mode_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  fifo_count;
    logic        overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    psum_post #(.DEPTH(DEPTH), .LEAK_SHIFT(LEAK_SHIFT)) dut (
        .clk           (clk),
        .rst           (rst),
        .psum_valid_in (psum_valid_in),
        .psum_in       (psum_in),
        .bias_load_in  (bias_load_in),
        .bias_in       (bias_in),
        .mode_in       (mode_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .fifo_count    (fifo_count),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    // Reference result: plain integer arithmetic on real Q8.8 values.
    function automatic logic [15:0] ref_post(input logic [15:0] p, input logic [15:0] b,
                                             input logic [1:0] m);
        int s;
        int div;
        div = 1 << LEAK_SHIFT;
        s = int'($signed(p)) + int'($signed(b));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (s < 0 && m == 2'b01) s = 0;
        if (s < 0 && m == 2'b10) s = -((-s + div - 1) / div);
        return 16'(s);
    endfunction

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow_err); end
        n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", out_data); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bias_in = 16'h0100; bias_load_in = 1'b1;
        step();
        bias_load_in = 1'b0;
        psum_in = 16'h08B2; mode_in = 2'b00; psum_valid_in = 1'b1;
        step();
        psum_valid_in = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: got valid %b want 0", out_valid); end
        step();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency2: got valid %b want 1", out_valid); end
        n_checks++; if (out_data !== 16'h09B2) begin n_fail++; $display("FAIL basic_data: got %h want 09B2", out_data); end
        step();
        n_checks++; if (out_data !== 16'h09B2) begin n_fail++; $display("FAIL basic_hold: got %h want 09B2", out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got valid %b want 0", out_valid); end
    endtask

    // Saturation and activation cases: one bias load, one psum, one drain each.
    task automatic test_activation();
        logic [15:0] tb_bias [7] = '{16'h0200, 16'hFE00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        logic [15:0] tb_psum [7] = '{16'h7F00, 16'h8100, 16'hDBF9, 16'hDBF9, 16'hDBF9, 16'hDBF9, 16'h0123};
        logic [1:0]  tb_mode [7] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10};
        logic [15:0] tb_exp  [7] = '{16'h7FFF, 16'h8000, 16'h0000, 16'hF6FE, 16'hDBF9, 16'hDBF9, 16'h0123};
        for (int i = 0; i < 7; i++) begin
            bias_in = tb_bias[i]; bias_load_in = 1'b1;
            step();
            bias_load_in = 1'b0;
            psum_in = tb_psum[i]; mode_in = tb_mode[i]; psum_valid_in = 1'b1;
            step();
            psum_valid_in = 1'b0;
            step();
            n_checks++; if (out_data !== tb_exp[i] || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL act_case%0d: got %h/%b want %h/1", i, out_data, out_valid, tb_exp[i]);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_bias_same_edge();
        // bias is 0 here; load 0x0500 on the same edge as the psum.
        bias_in = 16'h0500; bias_load_in = 1'b1;
        psum_in = 16'h0100; mode_in = 2'b00; psum_valid_in = 1'b1;
        step();
        bias_load_in = 1'b0;
        psum_in = 16'h0100;
        step();
        psum_valid_in = 1'b0;
        n_checks++; if (out_data !== 16'h0100) begin n_fail++; $display("FAIL bias_old: got %h want 0100", out_data); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_data !== 16'h0600) begin n_fail++; $display("FAIL bias_new: got %h want 0600", out_data); end
        step();
        out_ready = 1'b0;
        bias_in = 16'h0000; bias_load_in = 1'b1;
        step();
        bias_load_in = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0; mode_in = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            psum_in = 16'(i << 8); psum_valid_in = 1'b1;
            step();
        end
        psum_valid_in = 1'b0;
        step();
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow_err); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (out_data !== 16'(i << 8)) begin n_fail++; $display("FAIL ovf_order%0d: got %h want %h", i, out_data, 16'(i << 8)); end
            step();
        end
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got valid %b want 0", out_valid); end
        n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
    endtask

    task automatic test_full_rw();
        pulse_reset();
        out_ready = 1'b0; mode_in = 2'b00;
        for (int i = 0; i < 5; i++) begin
            psum_in = 16'((10 + i) << 8); psum_valid_in = 1'b1;
            step();
        end
        psum_valid_in = 1'b0;
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_pre: got %0d want 4", fifo_count); end
        out_ready = 1'b1;
        step();
        n_checks++; if (fifo_count !== 3'd4 || overflow_err !== 1'b0) begin
            n_fail++; $display("FAIL full_rw: got count %0d ovf %b want 4/0", fifo_count, overflow_err);
        end
        for (int i = 11; i <= 14; i++) begin
            n_checks++; if (out_data !== 16'(i << 8)) begin n_fail++; $display("FAIL full_order%0d: got %h want %h", i, out_data, 16'(i << 8)); end
            step();
        end
        out_ready = 1'b0;
    endtask

    // Continuous stream with consumer always ready: occupancy stays at 1.
    task automatic test_back_to_back();
        logic [15:0] vals [6];
        out_ready = 1'b1; mode_in = 2'b00;
        for (int i = 0; i < 6; i++) vals[i] = 16'($urandom_range(0, 16'h7FFF));
        for (int i = 0; i < 8; i++) begin
            psum_valid_in = (i < 6);
            psum_in = (i < 6) ? vals[i] : 16'h0000;
            step();
            if (i >= 1 && i <= 6) begin
                n_checks++; if (fifo_count !== 3'd1 || out_data !== vals[i-1]) begin
                    n_fail++; $display("FAIL b2b%0d: got %h cnt %0d want %h cnt 1", i, out_data, fifo_count, vals[i-1]);
                end
            end
        end
        psum_valid_in = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bias_in = 16'h0300; bias_load_in = 1'b1;
        step();
        bias_load_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            psum_in = 16'h0040; psum_valid_in = 1'b1;
            step();
        end
        psum_valid_in = 1'b0;
        step();
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++; $display("FAIL midrst: got valid %b cnt %0d want 0/0", out_valid, fifo_count);
        end
        step();
        rst = 1'b0;
        psum_in = 16'h0100; mode_in = 2'b00; psum_valid_in = 1'b1;
        step();
        psum_valid_in = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_lat: got valid %b want 0", out_valid); end
        step();
        n_checks++; if (out_data !== 16'h0100 || fifo_count !== 3'd1) begin
            n_fail++; $display("FAIL midrst_data: got %h cnt %0d want 0100 cnt 1", out_data, fifo_count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int          q[$];
        logic        pend_valid;
        logic [15:0] pend_val;
        logic [15:0] bias_m;
        logic        ovf_m;
        logic [15:0] exp_data;
        pulse_reset();
        pend_valid = 1'b0; pend_val = '0; bias_m = '0; ovf_m = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            psum_valid_in = ($urandom_range(0, 9) < 7);
            psum_in       = 16'($urandom);
            mode_in       = 2'($urandom);
            bias_load_in  = ($urandom_range(0, 9) == 0);
            bias_in       = 16'($urandom);
            out_ready     = ($urandom_range(0, 9) < 5);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (pend_valid) begin
                if (q.size() < DEPTH) q.push_back(int'(pend_val));
                else ovf_m = 1'b1;
            end
            pend_valid = psum_valid_in;
            pend_val   = ref_post(psum_in, bias_m, mode_in);
            if (bias_load_in) bias_m = bias_in;
            step();
            exp_data = (q.size() > 0) ? 16'(q[0]) : 16'h0000;
            n_checks++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, out_valid, q.size() > 0); end
            n_checks++; if (fifo_count !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, fifo_count, q.size()); end
            n_checks++; if (out_data !== exp_data) begin n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, out_data, exp_data); end
            n_checks++; if (overflow_err !== ovf_m) begin n_fail++; $display("FAIL rnd_ovf c%0d: got %b want %b", cyc, overflow_err, ovf_m); end
        end
        psum_valid_in = 1'b0; bias_load_in = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_activation();
        test_bias_same_edge();
        test_overflow();
        test_full_rw();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_post.md
PSUM_POST -- requirements
Module: psum_post

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-002 Parameter LEAK_SHIFT, default 2, arithmetic right-shift amount for leaky ReLU.
REQ-003 clk  in  1  single clock; all state on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 psum_valid_in  in  1  psum_in is valid this cycle (from bottom PE of column).
REQ-006 psum_in  in  16  signed Q8.8 partial sum from the column.
REQ-007 bias_load_in  in  1  latch bias_in into the bias register.
REQ-008 bias_in  in  16  signed Q8.8 bias.
REQ-009 mode_in  in  2  activation: 00 pass, 01 ReLU, 10 leaky ReLU, 11 pass (reserved).
REQ-010 out_valid  out  1  FIFO non-empty.
REQ-011 out_ready  in  1  consumer accepts out_data this cycle.
REQ-012 out_data  out  16  signed Q8.8 result at FIFO head.
REQ-013 fifo_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 overflow_err  out  1  sticky: a result was dropped because the FIFO was full.

Function
REQ-015 Stage 1 SHALL register, when psum_valid_in=1: 17-bit sign-extended sum psum_in+bias_reg, saturated to [0x8000,0x7FFF], plus mode_in and a valid bit.
REQ-016 bias_reg SHALL load bias_in on an edge with bias_load_in=1; stage 1 on that same edge SHALL use the old bias_reg value.
REQ-017 Stage 2 SHALL apply the stage-1 mode combinationally: pass -> unchanged; ReLU -> negative becomes 0x0000; leaky -> negative becomes value >>> LEAK_SHIFT (arithmetic, floor); non-negative always unchanged.
REQ-018 The stage-2 result SHALL be written into the FIFO on the edge after stage 1 captured it; psum accepted at edge N SHALL show out_valid=1 after edge N+1 when the FIFO was empty (no combinational bypass).
REQ-019 The block SHALL never stall upstream; a psum is accepted every cycle psum_valid_in=1.
REQ-020 FIFO read SHALL occur on an edge with out_valid=1 and out_ready=1; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Write to a full FIFO with no read on that edge SHALL drop the result, leave contents unchanged, and set overflow_err.
REQ-022 Simultaneous read and write when full SHALL succeed with no drop; fifo_count unchanged.
REQ-023 Simultaneous read and write at occupancy 1 SHALL output the old head and leave the new value as head.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; results leave in arrival order.
REQ-025 overflow_err SHALL clear only on reset.

Reset
REQ-026 On rst=1, immediately: out_valid=0, fifo_count=0, overflow_err=0, stage-1 valid=0, bias_reg=0x0000, pointers=0; out_data=0x0000.
REQ-027 Reset mid-operation SHALL discard all in-flight and buffered results; first post-reset psum follows REQ-018 latency.

Structure
REQ-028 Shared package SHALL hold Q8.8 width constant (16), FRAC_BITS (8), saturation limits, and the activation-mode enum; the same package serves the PE array.
REQ-029 The output FIFO SHALL be a sub-module named sync_fifo (parameters WIDTH, DEPTH); datapath stays in psum_post.

Verification
REQ-030 bias 0x0100 loaded, mode pass, psum 0x08B2 (8.6953125) -> out_data 0x09B2, out_valid high after second edge.
REQ-031 Saturation: psum 0x7F00 + bias 0x0200 -> 0x7FFF; psum 0x8100 + bias 0xFE00 -> 0x8000.
REQ-032 bias 0, psum 0xDBF9 (-36.02734375): ReLU -> 0x0000; leaky LEAK_SHIFT=2 -> 0xF6FE; pass -> 0xDBF9.
REQ-033 DEPTH=4, out_ready=0, five consecutive psums 1..5 (Q8.8) -> fifo_count=4, overflow_err=1; raising out_ready yields 1,2,3,4 in order.
REQ-034 FIFO full, out_ready=1 and psum_valid_in=1 same edge -> no overflow, count stays 4, new value emerges last.
REQ-035 Three entries buffered, bias 0x0300, rst pulsed -> out_valid=0, fifo_count=0 during reset; post-reset psum 0x0100 -> 0x0100 (bias cleared).
